// File: rtl/fnn_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed two-layer network.
// Hidden-layer ReLU is enabled by defining FNN_RELU_EN.
package fnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_L1,
    S_L2,
    S_DONE
  } fnn_state_e;

  localparam int DEF_INPUTS  = 3;
  localparam int DEF_HIDDEN  = 4;
  localparam int DEF_OUTPUTS = 2;
  localparam int DEF_L1_MACS = DEF_INPUTS * DEF_HIDDEN;
  localparam int DEF_L2_MACS = DEF_HIDDEN * DEF_OUTPUTS;
  localparam int DEF_LATENCY = DEF_L1_MACS + DEF_L2_MACS;

  // Wide enough that the longest dot product cannot overflow.
  function automatic int acc_width(input int dw, input int n_in, input int n_hid);
    int n;
    n = (n_in > n_hid) ? n_in : n_hid;
    return 2 * dw + $clog2(n) + 1;
  endfunction

  // Arithmetic shift (floor) then clamp to the signed dw-bit range; dw <= 64.
  function automatic logic signed [63:0] rescale_sat(input logic signed [127:0] acc,
                                                     input int frac, input int dw);
    logic signed [127:0] v;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    v  = acc >>> frac;
    hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (dw - 1));
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v[63:0];
  endfunction

endpackage

// File: rtl/fnn_mac.sv
// Signed multiply-accumulate: sum_o is the running total including the current product.
module fnn_mac #(
  parameter int DW    = 16,
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [DW-1:0]    a_i,
  input  logic signed [DW-1:0]    b_i,
  output logic signed [ACC_W-1:0] sum_o
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_q;

  assign prod  = a_i * b_i;
  assign sum_o = acc_q + ACC_W'(prod);

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= sum_o;
  end

endmodule

// File: rtl/fnn_seq.sv
// Sequential two-layer feed-forward network: one MAC per cycle, valid/ready on both sides.
// Define FNN_RELU_EN to apply ReLU to the hidden layer; otherwise the network is linear.
module fnn_seq
  import fnn_pkg::*;
#(
  parameter int INPUTS         = 3,
  parameter int HIDDEN_NEURONS = 4,
  parameter int OUTPUTS        = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [INPUTS*DATA_WIDTH-1:0]                 input_vector,
  input  logic [INPUTS*HIDDEN_NEURONS*DATA_WIDTH-1:0]  weights_input_hidden,
  input  logic [HIDDEN_NEURONS*OUTPUTS*DATA_WIDTH-1:0] weights_hidden_output,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [OUTPUTS*DATA_WIDTH-1:0]                output_vector
);

  localparam int DW    = DATA_WIDTH;
  localparam int ACC_W = acc_width(DW, INPUTS, HIDDEN_NEURONS);
  localparam int N_IH  = INPUTS * HIDDEN_NEURONS;
  localparam int N_HO  = HIDDEN_NEURONS * OUTPUTS;
  localparam int MAXN0 = (INPUTS > HIDDEN_NEURONS) ? INPUTS : HIDDEN_NEURONS;
  localparam int MAXN  = (MAXN0 > OUTPUTS) ? MAXN0 : OUTPUTS;
  localparam int CW    = (MAXN > 1) ? $clog2(MAXN) : 1;

  fnn_state_e              state_q;
  logic [CW-1:0]           inner_q;
  logic [CW-1:0]           outer_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [OUTPUTS*DW-1:0]   out_q;
  logic signed [DW-1:0]    x_q   [INPUTS];
  logic signed [DW-1:0]    wih_q [N_IH];
  logic signed [DW-1:0]    hid_q [HIDDEN_NEURONS];
  logic signed [DW-1:0]    who_q [N_HO];

  logic                    is_l2;
  logic                    mac_en;
  logic                    mac_clr;
  logic                    accept;
  logic                    inner_last;
  logic                    outer_last;
  logic signed [DW-1:0]    mac_a;
  logic signed [DW-1:0]    mac_b;
  logic signed [ACC_W-1:0] mac_sum;
  logic signed [DW-1:0]    res;
  logic signed [DW-1:0]    hid_new;

  assign is_l2      = (state_q == S_L2);
  assign mac_en     = (state_q == S_L1) || is_l2;
  assign accept     = (state_q == S_IDLE) && in_valid && in_ready_q;
  assign inner_last = is_l2 ? (inner_q == CW'(HIDDEN_NEURONS - 1)) : (inner_q == CW'(INPUTS - 1));
  assign outer_last = is_l2 ? (outer_q == CW'(OUTPUTS - 1)) : (outer_q == CW'(HIDDEN_NEURONS - 1));
  assign mac_clr    = accept || (mac_en && inner_last);

  // Operand banks rotate each MAC so the live operand is always element 0.
  assign mac_a = is_l2 ? hid_q[0] : x_q[0];
  assign mac_b = is_l2 ? who_q[0] : wih_q[0];

  assign res = DW'(rescale_sat(128'(mac_sum), FRAC_BITS, DW));

`ifdef FNN_RELU_EN
  assign hid_new = res[DW-1] ? '0 : res;
`else
  assign hid_new = res;
`endif

  fnn_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (mac_a),
    .b_i   (mac_b),
    .sum_o (mac_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      inner_q     <= '0;
      outer_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      // NOTE: storage arrays are reset too, because their post-reset value is defined as zero.
      for (int k = 0; k < INPUTS; k++)         x_q[k]   <= '0;
      for (int k = 0; k < N_IH; k++)           wih_q[k] <= '0;
      for (int k = 0; k < HIDDEN_NEURONS; k++) hid_q[k] <= '0;
      for (int k = 0; k < N_HO; k++)           who_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            for (int k = 0; k < INPUTS; k++) x_q[k]   <= input_vector[k*DW +: DW];
            for (int k = 0; k < N_IH; k++)   wih_q[k] <= weights_input_hidden[k*DW +: DW];
            for (int k = 0; k < N_HO; k++)   who_q[k] <= weights_hidden_output[k*DW +: DW];
            inner_q    <= '0;
            outer_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_L1;
          end
        end
        S_L1, S_L2: begin
          if (is_l2) begin
            for (int k = 0; k < N_HO - 1; k++) who_q[k] <= who_q[k+1];
            who_q[N_HO-1] <= who_q[0];
            for (int k = 0; k < HIDDEN_NEURONS - 1; k++) hid_q[k] <= hid_q[k+1];
            hid_q[HIDDEN_NEURONS-1] <= hid_q[0];
          end else begin
            for (int k = 0; k < N_IH - 1; k++) wih_q[k] <= wih_q[k+1];
            wih_q[N_IH-1] <= wih_q[0];
            for (int k = 0; k < INPUTS - 1; k++) x_q[k] <= x_q[k+1];
            x_q[INPUTS-1] <= x_q[0];
          end
          if (inner_last) begin
            inner_q <= '0;
            if (is_l2) begin
              for (int o = 0; o < OUTPUTS; o++)
                if (outer_q == CW'(o)) out_q[o*DW +: DW] <= res;
            end else begin
              // Finished neurons enter at the top; after the layer hidden[0] sits at index 0.
              for (int k = 0; k < HIDDEN_NEURONS - 1; k++) hid_q[k] <= hid_q[k+1];
              hid_q[HIDDEN_NEURONS-1] <= hid_new;
            end
            if (outer_last) begin
              outer_q <= '0;
              if (is_l2) begin
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                state_q <= S_L2;
              end
            end else begin
              outer_q <= outer_q + 1'b1;
            end
          end else begin
            inner_q <= inner_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign output_vector = out_q;

endmodule

// File: tb/tb_fnn_seq.sv
// Directed, table-driven bench for fnn_seq (Q0 instance plus a FRAC_BITS=8 instance).
// Expectations follow the FNN_RELU_EN build setting.
module tb_fnn_seq;
  import fnn_pkg::*;

  localparam int DW = 16;

  typedef struct packed {
    logic [3*DW-1:0]  x;
    logic [12*DW-1:0] wih;
    logic [8*DW-1:0]  who;
    logic [DW-1:0]    e0;
    logic [DW-1:0]    e1;
    logic [DW-1:0]    q0;
    logic [DW-1:0]    q1;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [3*DW-1:0]  input_vector = '0;
  logic [12*DW-1:0] w_ih = '0;
  logic [8*DW-1:0]  w_ho = '0;
  logic             in_ready, out_valid, in_ready8, out_valid8;
  logic [2*DW-1:0]  out_vec, out_vec8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fnn_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .input_vector(input_vector), .weights_input_hidden(w_ih), .weights_hidden_output(w_ho),
    .out_valid(out_valid), .out_ready(out_ready), .output_vector(out_vec)
  );

  fnn_seq #(.FRAC_BITS(8)) dut_q8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .input_vector(input_vector), .weights_input_hidden(w_ih), .weights_hidden_output(w_ho),
    .out_valid(out_valid8), .out_ready(out_ready), .output_vector(out_vec8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [12*DW-1:0] fill(input logic [DW-1:0] v, input int n);
    logic [12*DW-1:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  task automatic run_job(input vec_t v, input string tag, input bit ack);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    input_vector = v.x;
    w_ih = v.wih;
    w_ho = v.who;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    input_vector = '0;
    w_ih = '0;
    w_ho = '0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, DEF_LATENCY);
    check({tag, "_o0"}, 32'(out_vec[0 +: DW]), 32'(v.e0));
    check({tag, "_o1"}, 32'(out_vec[DW +: DW]), 32'(v.e1));
    check({tag, "_q8_o0"}, 32'(out_vec8[0 +: DW]), 32'(v.q0));
    check({tag, "_q8_o1"}, 32'(out_vec8[DW +: DW]), 32'(v.q1));
    if (ack) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  vec_t vecs[6];
  vec_t basic;

  initial begin
    logic [12*DW-1:0] w;
    bit stable;
    int n;

    w = '0;
    for (int h = 0; h < 4; h++)
      for (int i = 0; i < 3; i++) w[(h*3+i)*DW +: DW] = 16'(h + 1);

    vecs[0] = '{x: {16'd3, 16'd2, 16'd1}, wih: w, who: 128'(fill(16'd1, 8)),
                e0: 16'd60, e1: 16'd60, q0: 16'd0, q1: 16'd0};
    vecs[1] = '{x: {16'd4, 16'd3, 16'd2}, wih: w, who: 128'(fill(16'd1, 8)),
                e0: 16'd90, e1: 16'd90, q0: 16'd0, q1: 16'd0};
`ifdef FNN_RELU_EN
    vecs[2] = '{x: {16'hFFFD, 16'hFFFE, 16'hFFFF}, wih: fill(16'd1, 12), who: 128'(fill(16'd1, 8)),
                e0: 16'h0000, e1: 16'h0000, q0: 16'h0000, q1: 16'h0000};
    vecs[4] = '{x: 48'(fill(16'h8001, 3)), wih: fill(16'h7FFF, 12), who: 128'(fill(16'h7FFF, 8)),
                e0: 16'h0000, e1: 16'h0000, q0: 16'h0000, q1: 16'h0000};
`else
    vecs[2] = '{x: {16'hFFFD, 16'hFFFE, 16'hFFFF}, wih: fill(16'd1, 12), who: 128'(fill(16'd1, 8)),
                e0: 16'hFFE8, e1: 16'hFFE8, q0: 16'hFFFF, q1: 16'hFFFF};
    vecs[4] = '{x: 48'(fill(16'h8001, 3)), wih: fill(16'h7FFF, 12), who: 128'(fill(16'h7FFF, 8)),
                e0: 16'h8000, e1: 16'h8000, q0: 16'h8000, q1: 16'h8000};
`endif
    vecs[3] = '{x: 48'(fill(16'h7FFF, 3)), wih: fill(16'h7FFF, 12), who: 128'(fill(16'h7FFF, 8)),
                e0: 16'h7FFF, e1: 16'h7FFF, q0: 16'h7FFF, q1: 16'h7FFF};
    vecs[5] = '{x: 48'(fill(16'h0180, 3)), wih: fill(16'h0100, 12), who: 128'(fill(16'h0100, 8)),
                e0: 16'h7FFF, e1: 16'h7FFF, q0: 16'h1200, q1: 16'h1200};
    basic = vecs[0];

    // Reset and idle
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_output", 32'(out_vec), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_output", 32'(out_vec), 32'd0);

    for (int k = 0; k < 6; k++) run_job(vecs[k], $sformatf("vec%0d", k), 1'b1);

    // Busy rejection during L1, then backpressure hold in DONE
    @(negedge clk);
    input_vector = basic.x;
    w_ih = basic.wih;
    w_ho = basic.who;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_vector = vecs[1].x;
    repeat (3) @(negedge clk);
    check("busy_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_done_seen", 32'(out_valid), 32'd1);
    check("busy_result", 32'(out_vec), {16'd60, 16'd60});
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_vec !== {16'd60, 16'd60} || in_ready) stable = 1'b0;
    end
    check("backpressure_hold", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ack_out_valid", 32'(out_valid), 32'd0);
    check("ack_in_ready", 32'(in_ready), 32'd1);

    // Reset asserted mid-L2: outputs still hold the previous 60s until it hits
    input_vector = basic.x;
    w_ih = basic.wih;
    w_ho = basic.who;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midl2_rst_in_ready", 32'(in_ready), 32'd1);
    check("midl2_rst_output", 32'(out_vec), 32'd0);
    check("midl2_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_job(basic, "after_rst", 1'b0);

    // Reset asserted while DONE drops out_valid without a clock edge
    #2 rst = 1'b0;
    #1;
    check("done_rst_out_valid", 32'(out_valid), 32'd0);
    check("done_rst_output", 32'(out_vec), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fnn_seq.md
# fnn_seq

Time-multiplexed, parametrised two-layer feed-forward network (input → hidden → output) built around one signed multiply-accumulate unit and a valid/ready handshake. It is the sequential successor to the fully parallel `fnn`: one MAC per cycle, fixed-point scaling with saturation, and an optional hidden-layer ReLU. It sits between a sample producer (sensor/feature stage) and a downstream classifier or decision stage.

## Interface
- `INPUTS`, 3: input vector length, ≥1
- `HIDDEN_NEURONS`, 4: hidden layer size, ≥1
- `OUTPUTS`, 2: output vector length, ≥1
- `DATA_WIDTH`, 16: element width, signed two's complement, ≥4
- `FRAC_BITS`, 0: fractional bits of the Q format, 0 ≤ FRAC_BITS < DATA_WIDTH
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `in_valid` in 1: input vector and weights are valid
- `in_ready` out 1: block can accept a job
- `input_vector` in INPUTS*DATA_WIDTH: element i at bits [i*DW +: DW]
- `weights_input_hidden` in INPUTS*HIDDEN_NEURONS*DATA_WIDTH: weight (h,i) at [(h*INPUTS+i)*DW +: DW]
- `weights_hidden_output` in HIDDEN_NEURONS*OUTPUTS*DATA_WIDTH: weight (o,h) at [(o*HIDDEN_NEURONS+h)*DW +: DW]
- `out_valid` out 1: `output_vector` holds a finished result
- `out_ready` in 1: consumer takes the result
- `output_vector` out OUTPUTS*DATA_WIDTH: element o at [o*DW +: DW]

## Operation
- FSM states: IDLE, L1, L2, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: capture the input vector and both weight arrays into internal registers, clear the accumulator and indices, and go to L1. Ports may change freely after the accept edge.
- L1: one MAC per cycle over (h, i), i fastest. acc += x[i]*w_ih(h,i). On i = INPUTS−1: hidden[h] = act(sat(acc_final >>> FRAC_BITS)), clear acc. After h = HIDDEN_NEURONS−1, go to L2.
- L2: same scheme over (o, h) using the hidden registers; output[o] = sat(acc_final >>> FRAC_BITS), with no activation. After o = OUTPUTS−1, go to DONE.
- DONE: `out_valid`=1 and `output_vector` held stable. On `out_ready`, go to IDLE and drop `out_valid`. `in_ready`=0 in L1, L2 and DONE. Jobs presented while busy are not accepted.
- Arithmetic:
  - Product is 2*DW signed.
  - Accumulator is 2*DW + clog2(max(INPUTS, HIDDEN_NEURONS)) + 1 bits and never overflows.
  - Rescale is an arithmetic right shift by FRAC_BITS (truncation toward −∞).
  - Saturation clamps to [−2^(DW−1), 2^(DW−1)−1].
- Reset (asserted at any time, including mid-job):
  - FSM returns to IDLE and the partial job is discarded.
  - `out_valid`=0, `output_vector`=0, `in_ready`=1. Hidden, accumulator and captured registers are all 0.

## Timing
- Accept edge e0. L1 MACs on edges e1..e(I*H). L2 MACs on the next H*O edges.
- `out_valid` rises after edge e(I*H + H*O). Default parameters give 20 cycles.
- Result handshake edge eR returns the FSM to IDLE. The next accept can occur at eR+1 at the earliest, so throughput is 1 job per I*H + H*O + 2 cycles.
- `output_vector` changes only on the final L2 write of each output and on reset. It is stable whenever `out_valid`=1.

## Configuration
- `FNN_RELU_EN` defined: hidden activation act(v) = (v < 0) ? 0 : v.
- Not defined: act is the identity, so the network is a linear two-layer projection.
- The output layer never has an activation, in either build.

## Structure
- Package `fnn_pkg` holds:
  - the FSM state enum;
  - the accumulator width function;
  - the `sat`/rescale function;
  - localparams for MAC counts.
- Sub-module `fnn_mac`: signed multiplier plus accumulator with `clr` and `en` inputs, exposing the current sum. The top-level module owns the FSM, the indices and the storage.

## Test plan
All cases use default parameters, FRAC_BITS=0 unless stated.
- Reset and idle: hold `rst`=0 → `in_ready`=1, `out_valid`=0, `output_vector`=0. Release with no `in_valid` → no state change.
- Basic job:
  - Stimulus: x={1,2,3}, w_ih(h,i)=h+1, w_ho all 1.
  - Expected hidden: 6, 12, 18, 24.
  - Expected outputs: 60, 60, with `out_valid` exactly 20 cycles after accept.
- Backpressure and busy:
  - Hold `out_ready`=0 for 10 cycles → output stays stable and `out_valid` stays high.
  - Assert `in_valid` during L1 → not accepted, `in_ready`=0.
  - Second job x={2,3,4}, same weights → outputs 90, 90.
- ReLU:
  - Stimulus: x={−1,−2,−3}, all weights 1.
  - With `FNN_RELU_EN` → outputs 0, 0. Without it → outputs −24, −24.
- Saturation and fixed point:
  - x all 0x7FFF, weights all 0x7FFF → hidden and outputs 0x7FFF. With negated x and no ReLU → 0x8000.
  - FRAC_BITS=8: x=0x0180 (1.5), all weights 0x0100 → outputs 0x1200 (18.0).
- Mid-job reset: assert `rst`=0 during L2 → `out_valid`=0 immediately (asynchronous). After release, a fresh basic job gives the correct 60, 60.
